elevator_scheduler: RTL

Request scheduler and sequencer for the elevator car. Merges in-car requests with hall up/down calls into one pending-floor register and selects the next destination with a SCAN policy (keep direction while requests remain ahead). Runs the door-open dwell timer and halts on a stuck alarm. Sits upstream of the car block: it drives the car's `destination` input and consumes the car's `main_requests`, `stuck` and `maintenance_request` outputs.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_next_floor.sv | 35 +++
 rtl/elevator_scheduler.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared state encoding, sizing constants and floor validity check for the elevator scheduler.
package elevator_pkg;

    localparam int unsigned DEFAULT_NUM_FLOORS = 9;
    localparam int unsigned FLOOR_W            = 4;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StMove     = 2'd1,
        StDoorOpen = 2'd2,
        StHalt     = 2'd3
    } state_e;

    function automatic logic floor_invalid(input logic [FLOOR_W-1:0] f,
                                           input int unsigned num_floors);
        return (f == '0) || (32'(f) > num_floors);
    endfunction

endpackage

// File: rtl/elevator_next_floor.sv
// Nearest pending floor at or beyond the current floor in one direction (combinational).
module elevator_next_floor
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  dir_up,
    output logic                  found,
    output logic [FLOOR_W-1:0]    target
);

    // Scan away from the car so the last hit is the closest one.
    always_comb begin
        found  = 1'b0;
        target = '0;
        if (dir_up) begin
            for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
                if (pending[i] && (i + 1 >= int'(floor))) begin
                    found  = 1'b1;
                    target = FLOOR_W'(i + 1);
                end
            end
        end else begin
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (pending[i] && (i + 1 <= int'(floor))) begin
                    found  = 1'b1;
                    target = FLOOR_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler, door dwell timer and stuck-alarm halt for the elevator car.
// Optional ELEV_SCHED_MAINT_PARK_EN: maintenance parking at floor 1 with request masking.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS  = DEFAULT_NUM_FLOORS,
    parameter int unsigned DOOR_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] main_requests,
    input  logic [NUM_FLOORS-1:0] hall_up,
    input  logic [NUM_FLOORS-1:0] hall_down,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  stuck,
    input  logic                  maintenance_request,
    output logic [FLOOR_W-1:0]    destination,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy
);

    localparam int unsigned TIMER_W = $clog2(DOOR_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_CYCLES - 1);

    state_e                state_q;
    logic [FLOOR_W-1:0]    dest_q;
    logic                  door_q;
    logic                  dir_up_q;
    logic [NUM_FLOORS-1:0] pending_q;
    logic [TIMER_W-1:0]    timer_q;

    logic [NUM_FLOORS-1:0] req, req_eff, floor_oh, pending_d;
    logic                  invalid, pend_here, door_enter, reload, park;
    logic                  found_up, found_dn, found_fwd, found_bwd;
    logic [FLOOR_W-1:0]    tgt_up, tgt_dn, tgt_fwd, tgt_bwd, nearest;

`ifdef ELEV_SCHED_MAINT_PARK_EN
    assign park = maintenance_request;
`else
    logic unused_maint;
    assign unused_maint = maintenance_request;
    assign park         = 1'b0;
`endif

    elevator_next_floor #(.NUM_FLOORS(NUM_FLOORS)) u_next_up (
        .pending (pending_q),
        .floor   (floor),
        .dir_up  (1'b1),
        .found   (found_up),
        .target  (tgt_up)
    );

    elevator_next_floor #(.NUM_FLOORS(NUM_FLOORS)) u_next_dn (
        .pending (pending_q),
        .floor   (floor),
        .dir_up  (1'b0),
        .found   (found_dn),
        .target  (tgt_dn)
    );

    always_comb begin
        floor_oh = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_oh[i] = (32'(floor) == 32'(i + 1));
        end
        invalid   = floor_invalid(floor, NUM_FLOORS);
        pend_here = |(pending_q & floor_oh);
        req       = main_requests | hall_up | hall_down;

        found_fwd = dir_up_q ? found_up : found_dn;
        tgt_fwd   = dir_up_q ? tgt_up : tgt_dn;
        found_bwd = dir_up_q ? found_dn : found_up;
        tgt_bwd   = dir_up_q ? tgt_dn : tgt_up;

        // Equal distance favours the upward candidate.
        if (found_up && (!found_dn || ((tgt_up - floor) <= (floor - tgt_dn)))) begin
            nearest = tgt_up;
        end else begin
            nearest = tgt_dn;
        end

        door_enter = !stuck && !invalid && pend_here &&
                     (((state_q == StIdle) && !park) ||
                      ((state_q == StMove) && (dest_q == floor)));
        reload     = (state_q == StDoorOpen) && |(req & floor_oh);

        // Calls for the floor whose door is already open only extend the dwell.
        if (park) begin
            req_eff = '0;
        end else if (state_q == StDoorOpen) begin
            req_eff = req & ~floor_oh;
        end else begin
            req_eff = req;
        end
        pending_d = (pending_q | req_eff) & ~(door_enter ? floor_oh : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            dest_q    <= FLOOR_W'(1);
            door_q    <= 1'b0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            pending_q <= pending_d;
            if (stuck) begin
                state_q <= StHalt;
                door_q  <= 1'b0;
                timer_q <= '0;
                if (!invalid) dest_q <= floor;
            end else if (!invalid) begin
                unique case (state_q)
                    StIdle: begin
                        if (park) begin
                            dest_q <= FLOOR_W'(1);
                        end else if (door_enter) begin
                            state_q <= StDoorOpen;
                            dest_q  <= floor;
                            door_q  <= 1'b1;
                            timer_q <= TIMER_LOAD;
                        end else if (|pending_q) begin
                            state_q  <= StMove;
                            dest_q   <= nearest;
                            dir_up_q <= (nearest > floor);
                        end
                    end
                    StMove: begin
                        if (door_enter) begin
                            state_q <= StDoorOpen;
                            door_q  <= 1'b1;
                            timer_q <= TIMER_LOAD;
                        end else if (found_fwd) begin
                            dest_q <= tgt_fwd;
                        end else if (found_bwd) begin
                            dest_q   <= tgt_bwd;
                            dir_up_q <= ~dir_up_q;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StDoorOpen: begin
                        if (reload) begin
                            timer_q <= TIMER_LOAD;
                        end else if (timer_q != '0) begin
                            timer_q <= timer_q - 1'b1;
                        end else begin
                            door_q <= 1'b0;
                            if (park) begin
                                state_q <= StIdle;
                                dest_q  <= FLOOR_W'(1);
                            end else if (found_fwd) begin
                                state_q <= StMove;
                                dest_q  <= tgt_fwd;
                            end else if (found_bwd) begin
                                state_q  <= StMove;
                                dest_q   <= tgt_bwd;
                                dir_up_q <= ~dir_up_q;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    StHalt: begin
                        dest_q  <= floor;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign destination = dest_q;
    assign door_open   = door_q;
    assign pending     = pending_q;
    assign dir_up      = dir_up_q;
    assign busy        = (state_q != StIdle);

endmodule
